// File: rtl/instruction_fetch_unit.sv
// Fetch stage: streams sequential 32-bit reads from the icache into a small
// PC-tagged FIFO for the decoder, and discards in-flight words on a redirect.
module instruction_fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clock,
   input  logic        resetN,
   output logic        imemReq,
   output logic [63:0] imemAddr,
   input  logic        imemReady,
   input  logic        imemValid,
   input  logic [31:0] imemData,
   output logic [31:0] instruction,
   output logic [63:0] instrPC,
   output logic        instrValid,
   input  logic        instrReady,
   input  logic        redirect,
   input  logic [63:0] redirectTarget
);

   localparam int             CW      = $clog2(DEPTH) + 1;
   localparam int             PW      = $clog2(DEPTH);
   localparam logic [CW:0]    DEPTH_W = (CW + 1)'(DEPTH);

   logic [63:0]   fetch_pc;
   logic [63:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_count;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   data_mem [DEPTH];
   logic [63:0]   pc_mem   [DEPTH];

   logic          issue;
   logic          resp;
   logic          drop;
   logic          push;
   logic          pop;
   logic [CW:0]   in_use;
   logic [63:0]   target_aligned;

   // Credits cover both buffered and in-flight words, so a response can never
   // find the FIFO full.
   assign in_use         = {1'b0, count} + {1'b0, outstanding};
   assign imemReq        = resetN && !redirect && (in_use < DEPTH_W);
   assign imemAddr       = fetch_pc;
   assign issue          = imemReq && imemReady;
   assign resp           = imemValid && (outstanding != '0);
   assign drop           = resp && (redirect || (drop_count != '0));
   assign push           = resp && !drop;
   assign pop            = instrValid && instrReady && !redirect;
   assign target_aligned = redirectTarget & ~64'h3;

   assign instrValid  = (count != '0);
   assign instruction = instrValid ? data_mem[rd_ptr] : 32'h0;
   assign instrPC     = instrValid ? pc_mem[rd_ptr] : resp_pc;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_count  <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc    <= target_aligned;
         resp_pc     <= target_aligned;
         outstanding <= outstanding - CW'(resp);
         drop_count  <= outstanding - CW'(resp);
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (issue)
            fetch_pc <= fetch_pc + 64'd4;
         outstanding <= outstanding + CW'(issue) - CW'(resp);
         if (drop)
            drop_count <= drop_count - CW'(1);
         if (push) begin
            resp_pc <= resp_pc + 64'd4;
            wr_ptr  <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         data_mem[wr_ptr] <= imemData;
         pc_mem[wr_ptr]   <= resp_pc;
      end
   end

   // A response with nothing outstanding is an icache protocol violation.
   always_ff @(posedge clock) begin
      if (resetN)
         assert (!(imemValid && (outstanding == '0)));
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a small in-order icache model
// feeds the DUT; a monitor pops expected PCs as the decoder consumes words.
module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        imemReq;
   logic [63:0] imemAddr;
   logic        imemReady = 1'b0;
   logic        imemValid = 1'b0;
   logic [31:0] imemData = 32'h0;
   logic [31:0] instruction;
   logic [63:0] instrPC;
   logic        instrValid;
   logic        instrReady = 1'b0;
   logic        redirect = 1'b0;
   logic [63:0] redirectTarget = 64'h0;

   int          checks = 0;
   int          errors = 0;
   int          accepts = 0;
   bit          resp_en = 1'b0;
   logic [63:0] exp_q [$];
   logic [63:0] acc_q [$];
   logic [63:0] mon_e;

   instruction_fetch_unit #(.DEPTH(4), .RESET_PC(64'h0)) dut (
      .clock          (clock),
      .resetN         (resetN),
      .imemReq        (imemReq),
      .imemAddr       (imemAddr),
      .imemReady      (imemReady),
      .imemValid      (imemValid),
      .imemData       (imemData),
      .instruction    (instruction),
      .instrPC        (instrPC),
      .instrValid     (instrValid),
      .instrReady     (instrReady),
      .redirect       (redirect),
      .redirectTarget (redirectTarget)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [63:0] a);
      return 32'hA500_0000 ^ a[31:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // icache model: records accepted addresses, returns them in order one cycle later
   always @(negedge clock) begin
      if (!resetN) begin
         acc_q.delete();
      end else begin
         if (imemValid && acc_q.size() > 0)
            void'(acc_q.pop_front());
         if (imemReq && imemReady) begin
            acc_q.push_back(imemAddr);
            accepts++;
         end
      end
   end

   always @(posedge clock) begin
      #2;
      if (resetN && resp_en && acc_q.size() > 0) begin
         imemValid = 1'b1;
         imemData  = word_at(acc_q[0]);
      end else begin
         imemValid = 1'b0;
         imemData  = 32'h0;
      end
   end

   // scoreboard monitor
   always @(negedge clock) begin
      if (resetN && instrValid && instrReady && !redirect) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc %h required no delivery", instrPC);
         end else begin
            mon_e = exp_q.pop_front();
            check("deliver_pc", instrPC, mon_e);
            check("deliver_data", {32'h0, instruction}, {32'h0, word_at(mon_e)});
         end
      end
   end

   task automatic start(input bit ready, input bit dec_ready, input bit ren);
      @(posedge clock); #1;
      resetN = 1'b0;
      redirect = 1'b0;
      imemReady = 1'b0;
      instrReady = 1'b0;
      resp_en = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      imemReady = ready;
      instrReady = dec_ready;
      resp_en = ren;
      accepts = 0;
      resetN = 1'b1;
   endtask

   task automatic expect_seq(input logic [63:0] base, input int n);
      for (int k = 0; k < n; k++)
         exp_q.push_back(base + 64'(4 * k));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clock);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d words still pending after %0d cycles, required 0", exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      @(negedge clock);
      check("rst_req", imemReq, 1'b0);
      check("rst_valid", instrValid, 1'b0);
      check("rst_instr", instruction, 32'h0);
      check("rst_pc", instrPC, 64'h0);
      check("rst_addr", imemAddr, 64'h0);

      // 1: streaming, 1-cycle icache, decoder always ready
      start(1'b1, 1'b1, 1'b1);
      expect_seq(64'h0, 6);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (i == 0) begin
            check("t1_req", imemReq, 1'b1);
            check("t1_addr", imemAddr, 64'h0);
            check("t1_valid_c0", instrValid, 1'b0);
         end
         if (i == 1) check("t1_valid_c1", instrValid, 1'b0);
         if (i == 2) begin
            check("t1_valid_c2", instrValid, 1'b1);
            check("t1_first_pc", instrPC, 64'h0);
         end
         @(posedge clock);
      end
      #1 imemReady = 1'b0;
      drain(20);
      check("t1_accepts", accepts, 6);
      check("t1_next_addr", imemAddr, 64'd24);

      // 2: decoder stall fills FIFO, fetch resumes after first pop
      start(1'b1, 1'b0, 1'b1);
      repeat (10) @(posedge clock);
      @(negedge clock);
      check("t2_accepts", accepts, 4);
      check("t2_req_full", imemReq, 1'b0);
      check("t2_valid", instrValid, 1'b1);
      check("t2_head_pc", instrPC, 64'h0);
      check("t2_head_data", instruction, word_at(64'h0));
      check("t2_addr", imemAddr, 64'd16);
      expect_seq(64'h0, 5);
      @(posedge clock); #1 instrReady = 1'b1;
      @(negedge clock);
      check("t2_req_pop_cycle", imemReq, 1'b0);
      @(negedge clock);
      check("t2_req_after_pop", imemReq, 1'b1);
      check("t2_addr_after_pop", imemAddr, 64'd16);
      @(posedge clock); #1 imemReady = 1'b0;
      drain(20);
      check("t2_accepts_end", accepts, 5);

      // 3: redirect with two outstanding (8, 12)
      start(1'b1, 1'b1, 1'b0);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h4);
      expect_seq(64'h100, 4);
      repeat (4) @(posedge clock);
      #1 imemReady = 1'b0; resp_en = 1'b1;
      repeat (2) @(posedge clock);
      #1 resp_en = 1'b0;
      @(posedge clock); #1;
      redirect = 1'b1; redirectTarget = 64'h100; imemReady = 1'b1;
      @(negedge clock);
      check("t3_req_redirect", imemReq, 1'b0);
      @(posedge clock); #1;
      redirect = 1'b0; resp_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (i == 0) begin
            check("t3_req", imemReq, 1'b1);
            check("t3_addr", imemAddr, 64'h100);
         end
         if (i < 3) check("t3_empty", instrValid, 1'b0);
         @(posedge clock);
      end
      #1 imemReady = 1'b0;
      drain(20);
      check("t3_accepts", accepts, 8);

      // 4: redirect coincident with a returning word, unaligned target
      start(1'b1, 1'b1, 1'b0);
      expect_seq(64'h200, 4);
      @(posedge clock); #1;
      imemReady = 1'b0; redirect = 1'b1; redirectTarget = 64'h203; resp_en = 1'b1;
      @(negedge clock);
      check("t4_req_redirect", imemReq, 1'b0);
      @(posedge clock); #1;
      redirect = 1'b0; imemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (i == 0) begin
            check("t4_addr", imemAddr, 64'h200);
            check("t4_empty", instrValid, 1'b0);
         end
         @(posedge clock);
      end
      #1 imemReady = 1'b0;
      drain(20);
      check("t4_accepts", accepts, 5);

      // 5: back-to-back redirects with three in flight
      start(1'b1, 1'b1, 1'b0);
      expect_seq(64'h80, 4);
      repeat (3) @(posedge clock);
      #1 imemReady = 1'b0; redirect = 1'b1; redirectTarget = 64'h40;
      @(negedge clock);
      check("t5_req_r1", imemReq, 1'b0);
      @(posedge clock); #1;
      redirectTarget = 64'h80; resp_en = 1'b1;
      @(negedge clock);
      check("t5_req_r2", imemReq, 1'b0);
      check("t5_addr_r2", imemAddr, 64'h40);
      @(posedge clock); #1;
      redirect = 1'b0; imemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (i == 0) check("t5_addr", imemAddr, 64'h80);
         if (i < 3) check("t5_empty", instrValid, 1'b0);
         @(posedge clock);
      end
      #1 imemReady = 1'b0;
      drain(20);
      check("t5_accepts", accepts, 7);

      // 6: asynchronous reset with three buffered words
      start(1'b1, 1'b0, 1'b1);
      repeat (3) @(posedge clock);
      #1 imemReady = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      check("t6_valid_before", instrValid, 1'b1);
      check("t6_pc_before", instrPC, 64'h0);
      @(posedge clock); #3 resetN = 1'b0;
      #1;
      check("t6_valid_async", instrValid, 1'b0);
      check("t6_req_async", imemReq, 1'b0);
      expect_seq(64'h0, 3);
      start(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (i == 0) check("t6_restart_addr", imemAddr, 64'h0);
         @(posedge clock);
      end
      #1 imemReady = 1'b0;
      drain(20);
      check("t6_accepts", accepts, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
